// File: rtl/ld_result_bypass.sv
// Load-result tracker: pending-load FIFO, returned-data result register, per-source
// forward/stall decode and RF write-back. `LD_RESULT_BYPASS_FLUSH_EN adds a flush input.

module ld_result_bypass_src #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] fifo,
  input  logic [DEPTH-1:0]                    ent_vld,
  input  logic [RF_ADDR_WIDTH-1:0]            src_addr,
  input  logic                                res_valid,
  input  logic [RF_ADDR_WIDTH-1:0]            res_addr,
  input  logic [DATA_WIDTH-1:0]               res_data,
  output logic                                pend,
  output logic                                fwd_valid,
  output logic [DATA_WIDTH-1:0]               fwd_data
);
  logic nz, hit;

  assign nz = (src_addr != '0);

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i] && fifo[i] == src_addr) pend = 1'b1;
    pend = pend && nz;
  end

  // A younger in-flight load to the same register hides the older returned value
  assign hit       = res_valid && res_addr == src_addr && nz;
  assign fwd_valid = hit && !pend;
  assign fwd_data  = fwd_valid ? res_data : '0;
endmodule

module ld_result_bypass #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef LD_RESULT_BYPASS_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     ld_issue_valid,
  input  logic [RF_ADDR_WIDTH-1:0] ld_issue_rdaddr,
  output logic                     ld_issue_ready,
  input  logic                     dc_resp_valid,
  input  logic [DATA_WIDTH-1:0]    dc_resp_data,
  output logic                     dc_resp_ready,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_addr,
  output logic                     rs1_fwd_valid,
  output logic [DATA_WIDTH-1:0]    rs1_fwd_data,
  output logic                     rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0]    rs2_fwd_data,
  output logic                     ld_stall,
  output logic                     wb_valid,
  output logic [RF_ADDR_WIDTH-1:0] wb_rdaddr,
  output logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     wb_ready
);
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;
  localparam int NUM_LANES = 2;

  logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] fifo;
  logic [DEPTH-1:0]                    ent_vld;
  logic [PW-1:0]                       wr_ptr, rd_ptr;
  logic [CW-1:0]                       count;
  logic                                push, pop;
  logic                                res_valid;
  logic [RF_ADDR_WIDTH-1:0]            res_addr;
  logic [DATA_WIDTH-1:0]               res_data;

`ifdef LD_RESULT_BYPASS_FLUSH_EN
  logic [CW-1:0] drop_cnt;
  logic          draining, drop_dec;

  assign draining       = (drop_cnt != '0);
  assign drop_dec       = draining && dc_resp_valid;
  assign ld_issue_ready = !rst && (count != CW'(DEPTH)) && !draining;
  assign dc_resp_ready  = draining || !res_valid || wb_ready;

  // Stale responses still owed by the Dcache are swallowed here
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           drop_cnt <= '0;
    else if (flush)    drop_cnt <= drop_cnt + count - CW'(pop) - CW'(drop_dec);
    else if (drop_dec) drop_cnt <= drop_cnt - 1'b1;
  end
`else
  assign ld_issue_ready = !rst && (count != CW'(DEPTH));
  assign dc_resp_ready  = !res_valid || wb_ready;
`endif

  assign push = ld_issue_valid && ld_issue_ready;
  assign pop  = dc_resp_valid && dc_resp_ready && (count != '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr;
    assign ent_vld[i] = {1'b0, off} < count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`ifdef LD_RESULT_BYPASS_FLUSH_EN
    else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`endif
    else begin
      if (push) begin
        fifo[wr_ptr] <= ld_issue_rdaddr;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end
`ifdef LD_RESULT_BYPASS_FLUSH_EN
    else if (flush) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end
`endif
    else if (pop) begin
      res_valid <= 1'b1;
      res_addr  <= fifo[rd_ptr];
      res_data  <= dc_resp_data;
    end else if (res_valid && (wb_ready || res_addr == '0)) begin
      res_valid <= 1'b0;
    end
  end

  assign wb_valid  = res_valid && (res_addr != '0);
  assign wb_rdaddr = res_addr;
  assign wb_data   = res_data;

  logic [NUM_LANES-1:0][RF_ADDR_WIDTH-1:0] src_addr;
  logic [NUM_LANES-1:0]                    src_pend, src_fwd;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    src_data;

  assign src_addr = {rs2_addr, rs1_addr};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_src
    ld_result_bypass_src #(
      .RF_ADDR_WIDTH(RF_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)
    ) u_src (
      .fifo(fifo), .ent_vld(ent_vld), .src_addr(src_addr[l]),
      .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
      .pend(src_pend[l]), .fwd_valid(src_fwd[l]), .fwd_data(src_data[l])
    );
  end

  assign rs1_fwd_valid = src_fwd[0];
  assign rs1_fwd_data  = src_data[0];
  assign rs2_fwd_valid = src_fwd[1];
  assign rs2_fwd_data  = src_data[1];
  assign ld_stall      = |src_pend;
endmodule

// File: tb/tb_ld_result_bypass.sv
// Directed + random bench for ld_result_bypass against a queue-based reference model.
module tb_ld_result_bypass;
  localparam int AW = 5, DW = 32, DEPTH = 4;

  logic          clk = 0, rst = 1, flush = 0;
  logic          ld_issue_valid = 0, dc_resp_valid = 0, wb_ready = 1;
  logic [AW-1:0] ld_issue_rdaddr = 0, rs1_addr = 0, rs2_addr = 0;
  logic [DW-1:0] dc_resp_data = 0;
  logic          ld_issue_ready, dc_resp_ready, rs1_fwd_valid, rs2_fwd_valid, ld_stall, wb_valid;
  logic [DW-1:0] rs1_fwd_data, rs2_fwd_data, wb_data;
  logic [AW-1:0] wb_rdaddr;

  int n_chk = 0, n_fail = 0;

  // Reference model: queue of in-flight destinations + result register
  int unsigned q[$];
  bit          m_rv;
  int unsigned m_ra, m_rd, m_drop;

  always #5 clk = ~clk;

  ld_result_bypass #(.RF_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
`ifdef LD_RESULT_BYPASS_FLUSH_EN
    .flush(flush),
`endif
    .ld_issue_valid(ld_issue_valid), .ld_issue_rdaddr(ld_issue_rdaddr), .ld_issue_ready(ld_issue_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_ready(dc_resp_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
    .ld_stall(ld_stall), .wb_valid(wb_valid), .wb_rdaddr(wb_rdaddr), .wb_data(wb_data),
    .wb_ready(wb_ready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input int unsigned a);
    if (a == 0) return 0;
    foreach (q[i]) if (q[i] == a) return 1;
    return 0;
  endfunction

  function automatic bit m_ir();
    return (q.size() != DEPTH) && (m_drop == 0);
  endfunction

  function automatic bit m_rr();
    return (m_drop != 0) || !m_rv || wb_ready;
  endfunction

  task automatic chk_model();
    bit f1, f2;
    f1 = m_rv && m_ra == rs1_addr && rs1_addr != 0 && !m_pend(rs1_addr);
    f2 = m_rv && m_ra == rs2_addr && rs2_addr != 0 && !m_pend(rs2_addr);
    chk("issue_ready", ld_issue_ready, m_ir());
    chk("resp_ready", dc_resp_ready, m_rr());
    chk("rs1_fwd_valid", rs1_fwd_valid, f1);
    chk("rs1_fwd_data", rs1_fwd_data, f1 ? m_rd : 0);
    chk("rs2_fwd_valid", rs2_fwd_valid, f2);
    chk("rs2_fwd_data", rs2_fwd_data, f2 ? m_rd : 0);
    chk("ld_stall", ld_stall, m_pend(rs1_addr) || m_pend(rs2_addr));
    chk("wb_valid", wb_valid, m_rv && m_ra != 0);
    chk("wb_rdaddr", wb_rdaddr, m_ra);
    chk("wb_data", wb_data, m_rd);
  endtask

  task automatic chk_reset();
    chk("rst_issue_ready", ld_issue_ready, 0);
    chk("rst_resp_ready", dc_resp_ready, 1);
    chk("rst_rs1_fwd", rs1_fwd_valid, 0);
    chk("rst_rs1_data", rs1_fwd_data, 0);
    chk("rst_rs2_fwd", rs2_fwd_valid, 0);
    chk("rst_rs2_data", rs2_fwd_data, 0);
    chk("rst_stall", ld_stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rdaddr", wb_rdaddr, 0);
    chk("rst_wb_data", wb_data, 0);
  endtask

  task automatic m_clear();
    q.delete();
    m_rv = 0; m_ra = 0; m_rd = 0; m_drop = 0;
  endtask

  task automatic settle();
    #2;
    chk_model();
  endtask

  // Commit this cycle's handshakes into the model, then cross the clock edge
  task automatic adv();
    bit ir, rr, pop, dropr;
    ir = m_ir(); rr = m_rr();
    pop   = dc_resp_valid && rr && q.size() != 0;
    dropr = m_drop != 0 && dc_resp_valid;
    if (ld_issue_valid && q.size() == DEPTH) chk("push_while_full", ld_issue_ready, 0);
    if (flush) begin
      m_drop = m_drop + q.size() - pop - dropr;
      q.delete();
      m_rv = 0; m_ra = 0; m_rd = 0;
    end else begin
      if (dropr) m_drop--;
      if (pop) begin
        m_ra = q.pop_front(); m_rd = dc_resp_data; m_rv = 1;
      end else if (m_rv && (wb_ready || m_ra == 0)) m_rv = 0;
      if (ld_issue_valid && ir) q.push_back(ld_issue_rdaddr);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ld_issue_valid = 0; dc_resp_valid = 0; flush = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle(); wb_ready = 1;
    while ((q.size() != 0 || m_drop != 0) && n < 20) begin
      dc_resp_valid = 1; dc_resp_data = $urandom; settle(); adv(); n++;
    end
    idle(); settle(); adv();
    settle(); adv();
  endtask

  function automatic int unsigned t3_addr(input int k);
    return (k < 2) ? 10 + k : 12 + ((k - 2) % 4);
  endfunction

  initial begin
    m_clear();
    @(posedge clk); #1;
    #2; chk_reset();
    rst = 0;
    settle(); adv();

    // Stall then forward for a single load
    ld_issue_valid = 1; ld_issue_rdaddr = 5; settle(); adv();
    idle(); rs1_addr = 5; settle(); chk("t1_stall_a", ld_stall, 1); adv();
    dc_resp_valid = 1; dc_resp_data = 32'hDEADBEEF; settle(); chk("t1_stall_b", ld_stall, 1); adv();
    idle(); settle();
    chk("t1_fwd_valid", rs1_fwd_valid, 1); chk("t1_fwd_data", rs1_fwd_data, 32'hDEADBEEF);
    chk("t1_wb_valid", wb_valid, 1); chk("t1_wb_rd", wb_rdaddr, 5); chk("t1_stall_c", ld_stall, 0);
    adv(); rs1_addr = 0; drain();

    // Fill to DEPTH, fifth issue held off, in-order retire
    for (int i = 1; i <= 4; i++) begin
      ld_issue_valid = 1; ld_issue_rdaddr = AW'(i); settle(); adv();
    end
    ld_issue_rdaddr = 6; settle(); chk("t2_full", ld_issue_ready, 0); adv();
    ld_issue_valid = 0;
    for (int i = 0; i <= 4; i++) begin
      dc_resp_valid = (i < 4); dc_resp_data = 32'hA0 + i; settle();
      if (i > 0) begin
        chk("t2_wb_rd", wb_rdaddr, i); chk("t2_wb_data", wb_data, 32'hA0 + i - 1);
      end
      adv();
    end
    drain();

    // Simultaneous push/pop at count 2, pointers wrap several times
    for (int i = 0; i < 2; i++) begin
      ld_issue_valid = 1; ld_issue_rdaddr = AW'(t3_addr(i)); settle(); adv();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ld_issue_valid = 1; ld_issue_rdaddr = AW'(t3_addr(i + 2));
      dc_resp_valid = 1; dc_resp_data = i;
      settle(); chk("t3_ready", ld_issue_ready, 1);
      if (i > 0) begin
        chk("t3_wb_rd", wb_rdaddr, t3_addr(i - 1)); chk("t3_wb_data", wb_data, i - 1);
      end
      adv();
    end
    drain();

    // Younger pending load to the same register masks the older result
    rs2_addr = 9;
    ld_issue_valid = 1; ld_issue_rdaddr = 9; settle(); adv();
    settle(); adv();
    idle(); dc_resp_valid = 1; dc_resp_data = 32'h11; settle(); adv();
    dc_resp_data = 32'h22; settle();
    chk("t4_fwd_masked", rs2_fwd_valid, 0); chk("t4_stall", ld_stall, 1); adv();
    idle(); settle();
    chk("t4_fwd_valid", rs2_fwd_valid, 1); chk("t4_fwd_data", rs2_fwd_data, 32'h22);
    adv(); rs2_addr = 0; drain();

    // Back-pressure from the RF write port
    ld_issue_valid = 1; ld_issue_rdaddr = 3; settle(); adv();
    ld_issue_rdaddr = 4; settle(); adv();
    idle(); wb_ready = 0; dc_resp_valid = 1; dc_resp_data = 32'h33; settle(); adv();
    dc_resp_data = 32'h44; settle();
    chk("t5_resp_blocked", dc_resp_ready, 0); chk("t5_hold", wb_data, 32'h33); adv();
    settle(); chk("t5_hold2", wb_data, 32'h33); adv();
    wb_ready = 1; settle(); chk("t5_resp_ok", dc_resp_ready, 1); adv();
    idle(); settle(); chk("t5_wb_rd", wb_rdaddr, 4); chk("t5_wb_data", wb_data, 32'h44); adv();
    drain();

    // Load to x0: no stall, no write-back, self-clears without wb_ready
    wb_ready = 0; ld_issue_valid = 1; ld_issue_rdaddr = 0; rs1_addr = 0; settle(); adv();
    idle(); settle(); chk("t6_stall", ld_stall, 0);
    dc_resp_valid = 1; dc_resp_data = 32'h55; adv();
    idle(); settle(); chk("t6_wb_valid", wb_valid, 0); adv();
    settle(); chk("t6_self_clear", dc_resp_ready, 1); adv();
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ld_issue_valid  = $urandom_range(0, 1);
      ld_issue_rdaddr = AW'($urandom_range(0, 7));
      dc_resp_valid   = ($urandom_range(0, 2) != 0);
      dc_resp_data    = $urandom;
      wb_ready        = ($urandom_range(0, 3) != 0);
      rs1_addr        = AW'($urandom_range(0, 7));
      rs2_addr        = AW'($urandom_range(0, 7));
      settle(); adv();
    end
    drain();

`ifdef LD_RESULT_BYPASS_FLUSH_EN
    // Flush with three outstanding: exactly three stale responses are swallowed
    for (int i = 1; i <= 3; i++) begin
      ld_issue_valid = 1; ld_issue_rdaddr = AW'(i); settle(); adv();
    end
    ld_issue_rdaddr = 8; flush = 1; settle(); adv();
    flush = 0; ld_issue_rdaddr = 20;
    for (int i = 0; i < 3; i++) begin
      dc_resp_valid = 1; dc_resp_data = 32'hBAD0 + i; settle();
      chk("fl_issue_blocked", ld_issue_ready, 0); chk("fl_wb_valid", wb_valid, 0);
      adv();
    end
    idle(); settle(); chk("fl_issue_open", ld_issue_ready, 1); chk("fl_wb_none", wb_valid, 0);
    adv(); drain();
`endif

    // Asynchronous reset mid-stream
    wb_ready = 0;
    ld_issue_valid = 1; ld_issue_rdaddr = 7; settle(); adv();
    idle(); dc_resp_valid = 1; dc_resp_data = 32'h77; settle(); adv();
    idle(); ld_issue_valid = 1; ld_issue_rdaddr = 6; settle(); adv();
    idle(); rs1_addr = 6; rs2_addr = 7; #1;
    rst = 1; #1;
    chk_reset();
    m_clear();
    @(posedge clk); #1; rst = 0;
    wb_ready = 1;
    settle(); chk("post_rst_ready", ld_issue_ready, 1); adv();
    settle(); adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
